// File: rtl/interpolation_sequencer.sv
// Block-level sequencer for the interpolation datapath: walks PH -> PVPO -> PVSO -> DONE per block.
// Optional per-phase watchdog is compiled in with `define INTERP_WATCHDOG_EN.
module interpolation_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        ph_finished,
  input  logic        pvpo_finished,
  input  logic        pvso_finished,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        dp_enable,
  output logic        dp_reset,
  output logic        en_reg_int,
  output logic        en_sr_int,
  output logic        en_read_int,
  output logic        en_sr_hor,
  output logic        en_read_hor,
  output logic        en_clip,
  output logic        clip_pvso,
  output logic        mux_c1,
  output logic        mux_c0,
  output logic [15:0] block_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PH   = 3'd1,
    S_PVPO = 3'd2,
    S_PVSO = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_abort;
  logic   w_wd_fire;
  logic   w_timeout;
  logic   w_in_phase;

  assign w_in_phase = (r_state == S_PH) || (r_state == S_PVPO) || (r_state == S_PVSO);
  assign dbg_state  = r_state;

`ifdef INTERP_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wd_cnt;

  // Counter holds the number of cycles already spent in the current phase.
  assign w_timeout = w_in_phase && (r_wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (!w_in_phase || (w_next != r_state)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + WDW'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  // Abort outranks start and every finished flag; watchdog only fires if the phase did not finish.
  always_comb begin
    w_next    = r_state;
    w_abort   = 1'b0;
    w_wd_fire = 1'b0;
    case (r_state)
      S_IDLE: if (start && !abort) w_next = S_PH;
      S_PH: begin
        if (abort)             w_abort   = 1'b1;
        else if (ph_finished)  w_next    = S_PVPO;
        else if (w_timeout)    w_wd_fire = 1'b1;
      end
      S_PVPO: begin
        if (abort)              w_abort   = 1'b1;
        else if (pvpo_finished) w_next    = S_PVSO;
        else if (w_timeout)     w_wd_fire = 1'b1;
      end
      S_PVSO: begin
        if (abort)              w_abort   = 1'b1;
        else if (pvso_finished) w_next    = S_DONE;
        else if (w_timeout)     w_wd_fire = 1'b1;
      end
      S_DONE: begin
        w_next  = S_IDLE;
        w_abort = abort;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort || w_wd_fire) w_next = S_IDLE;
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      dp_enable   <= 1'b0;
      dp_reset    <= 1'b1;
      en_reg_int  <= 1'b0;
      en_sr_int   <= 1'b0;
      en_read_int <= 1'b0;
      en_sr_hor   <= 1'b0;
      en_read_hor <= 1'b0;
      en_clip     <= 1'b0;
      clip_pvso   <= 1'b0;
      mux_c1      <= 1'b0;
      mux_c0      <= 1'b0;
      block_count <= 16'h0000;
`ifdef INTERP_WATCHDOG_EN
      error       <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      busy        <= (w_next != S_IDLE);
      done        <= (w_next == S_DONE);
      dp_enable   <= (w_next == S_PH) || (w_next == S_PVPO) || (w_next == S_PVSO);
      dp_reset    <= w_abort || w_wd_fire;
      en_reg_int  <= (w_next == S_PH);
      en_sr_int   <= (w_next == S_PH);
      en_sr_hor   <= (w_next == S_PH);
      en_read_int <= (w_next == S_PVPO);
      en_read_hor <= (w_next == S_PVSO);
      en_clip     <= (w_next == S_PVPO) || (w_next == S_PVSO);
      clip_pvso   <= (w_next == S_PVSO);
      mux_c1      <= (w_next == S_PVSO);
      mux_c0      <= (w_next == S_PVPO);
      if (w_next == S_DONE) block_count <= block_count + 16'd1;
`ifdef INTERP_WATCHDOG_EN
      error       <= w_wd_fire;
`endif
    end
  end

endmodule

// File: tb/tb_interpolation_sequencer.sv
// Randomised scoreboard bench for interpolation_sequencer; block outcomes are queued by the
// driver and retired by an independent monitor. Watchdog checks follow INTERP_WATCHDOG_EN.
module tb_interpolation_sequencer;

  localparam logic [1:0] K_DONE  = 2'd1;
  localparam logic [1:0] K_ABORT = 2'd2;
  localparam logic [1:0] K_ERROR = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ph_finished = 1'b0;
  logic        pvpo_finished = 1'b0;
  logic        pvso_finished = 1'b0;
  logic        busy, done, error, dp_enable, dp_reset;
  logic        en_reg_int, en_sr_int, en_read_int, en_sr_hor, en_read_hor, en_clip, clip_pvso;
  logic        mux_c1, mux_c0;
  logic [15:0] block_count;
  logic [2:0]  dbg_state;

  logic [17:0] exp_q[$];
  logic [15:0] m_count = 16'h0000;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  interpolation_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .ph_finished(ph_finished), .pvpo_finished(pvpo_finished), .pvso_finished(pvso_finished),
    .busy(busy), .done(done), .error(error), .dp_enable(dp_enable), .dp_reset(dp_reset),
    .en_reg_int(en_reg_int), .en_sr_int(en_sr_int), .en_read_int(en_read_int),
    .en_sr_hor(en_sr_hor), .en_read_hor(en_read_hor), .en_clip(en_clip), .clip_pvso(clip_pvso),
    .mux_c1(mux_c1), .mux_c0(mux_c0), .block_count(block_count), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level control table: {dp_enable,en_reg_int,en_sr_int,en_read_int,en_sr_hor,en_read_hor,en_clip,clip_pvso}
  function automatic logic [7:0] exp_ctrl(input logic b, input logic d, input logic [1:0] sel);
    if (!b || d) return 8'b0000_0000;
    case (sel)
      2'b00:   return 8'b1110_1000;
      2'b01:   return 8'b1001_0010;
      2'b10:   return 8'b1000_0111;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [17:0] e;
    logic        prev_busy;
    logic [1:0]  last_sel;
    int          seq;
    prev_busy = 1'b0;
    last_sel  = 2'b00;
    seq       = 0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        check("sel_legal", 32'({mux_c1, mux_c0} != 2'b11), 32'd1);
        check("ctrl", 32'({dp_enable, en_reg_int, en_sr_int, en_read_int, en_sr_hor,
                           en_read_hor, en_clip, clip_pvso}),
              32'(exp_ctrl(busy, done, {mux_c1, mux_c0})));
        if (busy && !done) begin
          if (!prev_busy) begin
            seq = int'({mux_c1, mux_c0});
            last_sel = {mux_c1, mux_c0};
          end else if ({mux_c1, mux_c0} != last_sel) begin
            last_sel = {mux_c1, mux_c0};
            seq = seq * 4 + int'(last_sel);
          end
        end
        if (done || dp_reset) begin
          if (exp_q.size() == 0) begin
            check("queue_empty_on_event", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            if (done) begin
              check("done_kind", 32'(K_DONE), 32'(e[17:16]));
              check("done_count", 32'(block_count), 32'(e[15:0]));
              check("select_sequence", 32'(seq), 32'd6);
              check("done_no_dp_reset", 32'(dp_reset), 32'd0);
            end else begin
              check("kill_kind", 32'(error ? K_ERROR : K_ABORT), 32'(e[17:16]));
              check("kill_count", 32'(block_count), 32'(e[15:0]));
            end
          end
        end else begin
          check("error_idle", 32'(error), 32'd0);
        end
        prev_busy = busy;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_flags(input int which, input logic own, input logic noisy_start);
    ph_finished   = (which == 0) ? own : 1'($urandom_range(0, 1));
    pvpo_finished = (which == 1) ? own : 1'($urandom_range(0, 1));
    pvso_finished = (which == 2) ? own : 1'($urandom_range(0, 1));
    start         = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic clear_inputs();
    ph_finished = 1'b0; pvpo_finished = 1'b0; pvso_finished = 1'b0;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic drive_phase(input int which, input int n, input logic noisy_start);
    repeat (n) begin
      set_flags(which, 1'b0, noisy_start);
      @(negedge clock);
    end
  endtask

  task automatic finish_phase(input int which);
    set_flags(which, 1'b1, 1'b1);
    if (which == 2) begin
      m_count = m_count + 16'd1;
      exp_q.push_back({K_DONE, m_count});
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic issue_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_latency", 32'(busy), 32'd1);
    check("ph_select", 32'({mux_c1, mux_c0}), 32'd0);
  endtask

  task automatic run_block(input int d0, input int d1, input int d2, input logic start_mid);
    issue_start();
    drive_phase(0, d0, 1'b1);
    finish_phase(0);
    check("pvpo_select", 32'({mux_c1, mux_c0}), 32'd1);
    if (start_mid) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    drive_phase(1, d1, 1'b1);
    finish_phase(1);
    check("pvso_select", 32'({mux_c1, mux_c0}), 32'd2);
    drive_phase(2, d2, 1'b1);
    finish_phase(2);
    check("done_latency", 32'(done), 32'd1);
    @(negedge clock);
    check("idle_after_done", 32'({busy, done}), 32'd0);
    check("count_after_block", 32'(block_count), 32'(m_count));
  endtask

  task automatic abort_block(input int at, input int d);
    issue_start();
    for (int p = 0; p < at; p++) begin
      drive_phase(p, int'($urandom_range(0, 5)), 1'b1);
      finish_phase(p);
    end
    drive_phase(at, d, 1'b1);
    set_flags(at, 1'($urandom_range(0, 1)), 1'b1);
    abort = 1'b1;
    exp_q.push_back({K_ABORT, m_count});
    @(negedge clock);
    clear_inputs();
    check("abort_to_idle", 32'(busy), 32'd0);
    check("abort_dp_reset", 32'(dp_reset), 32'd1);
    check("abort_no_done", 32'(done), 32'd0);
    @(negedge clock);
    check("abort_dp_reset_1cyc", 32'(dp_reset), 32'd0);
    check("abort_count", 32'(block_count), 32'(m_count));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({busy, done, error, dp_enable, en_reg_int, en_sr_int, en_read_int,
                                en_sr_hor, en_read_hor, en_clip, clip_pvso, mux_c1, mux_c0}), 32'd0);
    check("reset_dp_reset", 32'(dp_reset), 32'd1);
    check("reset_count", 32'(block_count), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_dp_reset", 32'(dp_reset), 32'd0);
    mon_en = 1'b1;

    run_block(15, 7, 26, 1'b0);
    check("first_block_count", 32'(block_count), 32'd1);
    run_block(3, 4, 2, 1'b1);
    abort_block(2, 3);
    abort_block(0, 0);
    abort_block(1, 2);

    // abort together with start in IDLE does nothing
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    clear_inputs();
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_dp_reset", 32'(dp_reset), 32'd0);

    // reset in the middle of PH
    issue_start();
    drive_phase(0, 3, 1'b0);
    clear_inputs();
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("midph_reset_outputs", 32'({busy, done, error, dp_enable, en_reg_int, en_sr_int, en_read_int,
                                      en_sr_hor, en_read_hor, en_clip, clip_pvso, mux_c1, mux_c0}), 32'd0);
    check("midph_reset_dp_reset", 32'(dp_reset), 32'd1);
    check("midph_reset_count", 32'(block_count), 32'd0);
    reset = 1'b0;
    m_count = 16'h0000;
    @(negedge clock);
    check("midph_post_dp_reset", 32'(dp_reset), 32'd0);
    mon_en = 1'b1;
    run_block(1, 1, 1, 1'b0);

    // block counter wrap
    force dut.block_count = 16'hFFFF;
    @(negedge clock);
    release dut.block_count;
    m_count = 16'hFFFF;
    run_block(2, 0, 1, 1'b0);
    check("wrap_count", 32'(block_count), 32'd0);

    // stalled PH
    issue_start();
`ifdef INTERP_WATCHDOG_EN
    exp_q.push_back({K_ERROR, m_count});
    repeat (63) @(negedge clock);
    check("wd_before_timeout", 32'({busy, error}), 32'b10);
    @(negedge clock);
    check("wd_error_pulse", 32'(error), 32'd1);
    check("wd_to_idle", 32'(busy), 32'd0);
    check("wd_dp_reset", 32'(dp_reset), 32'd1);
    @(negedge clock);
    check("wd_error_1cyc", 32'(error), 32'd0);
`else
    repeat (100) @(negedge clock);
    check("no_wd_still_busy", 32'(busy), 32'd1);
    check("no_wd_error", 32'(error), 32'd0);
    abort = 1'b1;
    exp_q.push_back({K_ABORT, m_count});
    @(negedge clock);
    clear_inputs();
    check("no_wd_abort_idle", 32'(busy), 32'd0);
    @(negedge clock);
`endif

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0)
        abort_block(int'($urandom_range(0, 2)), int'($urandom_range(0, 6)));
      else
        run_block(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_count", 32'(block_count), 32'(m_count));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/interpolation_sequencer.md
INTERPOLATION_SEQUENCER -- requirements
Module: interpolation_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the maximum cycles per phase before the watchdog fires.
REQ-002 SHALL have port clock, input, 1, rising-edge clock; reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, request to process one block; sampled in IDLE only.
REQ-004 SHALL have port abort, input, 1, synchronous cancel of the current block.
REQ-005 SHALL have ports ph_finished, pvpo_finished and pvso_finished, each input, 1, level phase-complete flags from the datapath.
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-007 SHALL have port done, output, 1, one-cycle pulse when a block completes.
REQ-008 SHALL have port error, output, 1, one-cycle pulse when the watchdog fires.
REQ-009 SHALL have port dp_enable, output, 1, datapath cycle-counter enable.
REQ-010 SHALL have port dp_reset, output, 1, datapath synchronous reset pulse.
REQ-011 SHALL have ports en_reg_int, en_sr_int, en_read_int, en_sr_hor, en_read_hor, en_clip and clip_pvso, each output, 1, datapath stage controls.
REQ-012 SHALL have ports mux_c1 and mux_c0, outputs, 1 each, forming the datapath operand-select code.
REQ-013 SHALL have port block_count, output, 16, count of completed blocks.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, PH, PVPO, PVSO and DONE; all outputs SHALL be registered.
REQ-015 IDLE: all controls 0 and {mux_c1,mux_c0}=00.
- start=1 with abort=0 -> PH on the next edge.
REQ-016 PH: dp_enable, en_reg_int, en_sr_int and en_sr_hor =1; select 00.
- ph_finished=1 -> PVPO.
REQ-017 PVPO: dp_enable, en_read_int and en_clip =1; clip_pvso=0; select 01.
- pvpo_finished=1 -> PVSO.
REQ-018 PVSO: dp_enable, en_read_hor, en_clip and clip_pvso =1; select 10.
- pvso_finished=1 -> DONE.
REQ-019 DONE: done=1, dp_enable=0, block_count increments by 1 (wrapping FFFF->0000); IDLE follows unconditionally after one cycle.
REQ-020 Latency: busy rises one cycle after start is sampled; done rises one cycle after pvso_finished is sampled.
REQ-021 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-022 A finished flag for a phase other than the current phase SHALL be ignored.
REQ-023 abort in any non-IDLE state:
- next state IDLE;
- dp_reset=1 for exactly one cycle;
- no done pulse;
- block_count unchanged.
REQ-024 abort in IDLE SHALL be a no-op; abort has priority over start and over every finished flag in the same cycle.
REQ-025 Select code 11 SHALL never be driven.

Reset
REQ-026 reset SHALL force IDLE in every state, including mid-phase.
REQ-027 On reset, block_count, the watchdog counter and every output SHALL be 0, except dp_reset, which SHALL be 1 during the reset cycle.

Configuration
REQ-028 With macro INTERP_WATCHDOG_EN defined, a per-phase counter SHALL clear on each phase entry and increment each cycle in PH, PVPO and PVSO.
- Reaching TIMEOUT_CYCLES -> error pulse + dp_reset pulse + IDLE; block_count unchanged.
REQ-029 Without INTERP_WATCHDOG_EN, the watchdog counter SHALL be absent, error SHALL be tied 0, and phases SHALL wait indefinitely.

Verification
REQ-030 start pulse; ph_finished at cycle 16, pvpo_finished at cycle 24, pvso_finished at cycle 51 -> select sequence 00/01/10, a single done pulse, block_count=1.
REQ-031 start asserted again during PVPO -> ignored; exactly one done pulse; block_count=1.
REQ-032 abort during PVSO -> IDLE next cycle, dp_reset high for 1 cycle, no done pulse, block_count unchanged.
REQ-033 With INTERP_WATCHDOG_EN and TIMEOUT_CYCLES=64, ph_finished held at 0 -> error pulse 64 cycles after PH entry, then IDLE.
REQ-034 Preload block_count=FFFF and complete one block -> block_count=0000.
REQ-035 reset during PH -> next cycle IDLE with all outputs 0; a start issued afterwards runs normally.
